// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM host request sequencer.
package sdram_pkg;

  localparam int HADDR_WIDTH_DEF = 25;
  localparam int DATA_WIDTH      = 8;
  localparam int ENTRY_WIDTH     = 1 + HADDR_WIDTH_DEF + DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACC,
    S_WAIT_DONE,
    S_GAP
  } seq_state_t;

  function automatic int entry_w(input int aw);
    return 1 + aw + DATA_WIDTH;
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Show-ahead request FIFO; the head is visible whenever the FIFO is non-empty.
module sdram_req_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/sdram_req_sequencer.sv
// Turns queued host byte requests into single-cycle controller pulses,
// confirms acceptance through busy and reissues pulses lost to refresh.
module sdram_req_sequencer
  import sdram_pkg::*;
#(
  parameter int HADDR_WIDTH    = HADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int ACCEPT_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [HADDR_WIDTH-1:0]        req_addr,
  input  logic [7:0]                    req_wdata,
  output logic                          rsp_valid,
  output logic [7:0]                    rsp_rdata,
  output logic [HADDR_WIDTH-1:0]        ctl_wr_addr,
  output logic [HADDR_WIDTH-1:0]        ctl_rd_addr,
  output logic [7:0]                    ctl_wr_data,
  output logic                          ctl_wr_enable,
  output logic                          ctl_rd_enable,
  input  logic                          ctl_busy,
  input  logic [7:0]                    ctl_rd_data,
  input  logic                          ctl_rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    retry_count
);

  localparam int EW = entry_w(HADDR_WIDTH);
  localparam int CW = $clog2(ACCEPT_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(ACCEPT_TIMEOUT - 1);

  seq_state_t             state;
  logic [CW-1:0]          to_cnt;
  logic                   retry;
  logic                   h_write;
  logic [HADDR_WIDTH-1:0] h_addr;
  logic [7:0]             h_wdata;

  logic [EW-1:0]          head;
  logic                   hd_write;
  logic [HADDR_WIDTH-1:0] hd_addr;
  logic [7:0]             hd_wdata;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign {hd_write, hd_addr, hd_wdata} = head;

  // The head leaves the FIFO only once the controller has finished with it.
  assign pop = (state == S_WAIT_DONE) &&
               (h_write ? !ctl_busy : ctl_rd_ready);

  assign ctl_wr_addr = h_addr;
  assign ctl_rd_addr = h_addr;
  assign ctl_wr_data = h_wdata;

  sdram_req_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({req_write, req_addr, req_wdata}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      to_cnt        <= '0;
      retry         <= 1'b0;
      h_write       <= 1'b0;
      h_addr        <= '0;
      h_wdata       <= '0;
      ctl_wr_enable <= 1'b0;
      ctl_rd_enable <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      retry_count   <= '0;
    end else begin
      ctl_wr_enable <= 1'b0;
      ctl_rd_enable <= 1'b0;
      rsp_valid     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!empty && !ctl_busy) begin
            h_write       <= hd_write;
            h_addr        <= hd_addr;
            h_wdata       <= hd_wdata;
            ctl_wr_enable <= hd_write;
            ctl_rd_enable <= !hd_write;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          to_cnt <= '0;
          state  <= S_WAIT_ACC;
        end
        S_WAIT_ACC: begin
          if (ctl_busy) begin
            state <= S_WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            if (retry_count != 8'hFF)
              retry_count <= retry_count + 8'd1;
            retry <= 1'b1;
            state <= S_GAP;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (h_write) begin
            if (!ctl_busy) state <= S_GAP;
          end else if (ctl_rd_ready) begin
            rsp_rdata <= ctl_rd_data;
            rsp_valid <= 1'b1;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          // A lost pulse is reissued straight from the held entry.
          retry <= 1'b0;
          if (retry) begin
            ctl_wr_enable <= h_write;
            ctl_rd_enable <= !h_write;
            state         <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_req_sequencer.sv
// Scoreboard bench: controller model plus reference memory for the sequencer.
module tb_sdram_req_sequencer;

  localparam int AW    = 25;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_wdata = '0;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic [AW-1:0] ctl_wr_addr;
  logic [AW-1:0] ctl_rd_addr;
  logic [7:0]    ctl_wr_data;
  logic          ctl_wr_enable;
  logic          ctl_rd_enable;
  logic          ctl_busy = 1'b0;
  logic [7:0]    ctl_rd_data = '0;
  logic          ctl_rd_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0]    retry_count;

  sdram_req_sequencer #(
    .HADDR_WIDTH    (AW),
    .FIFO_DEPTH     (DEPTH),
    .ACCEPT_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .ctl_wr_addr   (ctl_wr_addr),
    .ctl_rd_addr   (ctl_rd_addr),
    .ctl_wr_data   (ctl_wr_data),
    .ctl_wr_enable (ctl_wr_enable),
    .ctl_rd_enable (ctl_rd_enable),
    .ctl_busy      (ctl_busy),
    .ctl_rd_data   (ctl_rd_data),
    .ctl_rd_ready  (ctl_rd_ready),
    .fifo_count    (fifo_count),
    .retry_count   (retry_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } cmd_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_rsp[$];
  logic [7:0] rmem [logic [AW-1:0]];
  logic [7:0] cmem [logic [AW-1:0]];

  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ctl_rd(input logic [AW-1:0] a);
    return cmem.exists(a) ? cmem[a] : dflt(a);
  endfunction

  // Controller model: busy rises 2 cycles after an accepted pulse,
  // read data strobes while busy, dropped pulses produce nothing.
  bit          stall = 0;
  bit          drop_next = 0;
  bit          rand_drop = 0;
  int          force_lat = 0;
  bit          act = 0;
  bit          act_wr = 0;
  int unsigned st = 0;
  int unsigned lat = 1;
  logic [AW-1:0] act_a = '0;
  bit          prev_en = 0;
  bit          have_last = 0;
  int unsigned last_p = 0;
  int unsigned pulse_q[$];
  int          drops = 0;
  int          rsp_seen = 0;

  always @(posedge clk) begin
    bit en;
    bit drop;
    int unsigned k;
    logic [7:0] e;
    #1;
    en = ctl_wr_enable || ctl_rd_enable;
    if (!rst && en) begin
      check("one_enable", 64'(ctl_wr_enable & ctl_rd_enable), 0);
      check("no_back_to_back", 64'(prev_en), 0);
      if (have_last)
        check("pulse_gap", 64'(cyc - last_p >= 3), 1);
      check("addr_alias", 64'(ctl_rd_addr), 64'(ctl_wr_addr));
      have_last = 1;
      last_p = cyc;
      pulse_q.push_back(cyc);
      if (exp_cmd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulse expected none at %0d", cyc);
      end else begin
        check("cmd_write", 64'(ctl_wr_enable), 64'(exp_cmd[0].w));
        check("cmd_addr", 64'(ctl_wr_addr), 64'(exp_cmd[0].a));
        if (exp_cmd[0].w)
          check("cmd_wdata", 64'(ctl_wr_data), 64'(exp_cmd[0].d));
      end
      drop = drop_next || (rand_drop && $urandom_range(0, 7) == 0);
      drop_next = 0;
      if (drop) begin
        drops++;
      end else begin
        act = 1;
        st = cyc;
        act_wr = ctl_wr_enable;
        act_a = ctl_wr_addr;
        lat = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
        if (act_wr) cmem[act_a] = ctl_wr_data;
        if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
      end
    end
    prev_en = en;
    ctl_rd_ready = 0;
    if (act) begin
      k = cyc - st;
      if (!act_wr && k == 2 + lat) begin
        ctl_rd_ready = 1;
        ctl_rd_data = ctl_rd(act_a);
      end
      if (k >= 3 + lat) act = 0;
    end
    ctl_busy = stall || (act && (cyc - st) >= 2);
    if (rsp_valid && !rst) begin
      rsp_seen++;
      if (exp_rsp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got %0h expected none", rsp_rdata);
      end else begin
        e = exp_rsp.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e));
      end
    end
  end

  task automatic push(input bit w, input logic [AW-1:0] a,
                      input logic [7:0] d);
    cmd_t c;
    int n = 0;
    @(negedge clk);
    req_valid = 1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("push_timeout", 64'(req_ready), 1);
      req_valid = 0;
    end else begin
      @(posedge clk);
      c.w = w;
      c.a = a;
      c.d = d;
      exp_cmd.push_back(c);
      if (w) rmem[a] = d;
      else exp_rsp.push_back(ref_rd(a));
      #1 req_valid = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 ||
            fifo_count != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 64'(n < 5000), 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 1);
    check({tag, "_fifo_count"}, 64'(fifo_count), 0);
    check({tag, "_retry_count"}, 64'(retry_count), 0);
    check({tag, "_enables"}, 64'({ctl_wr_enable, ctl_rd_enable}), 0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 0);
    check({tag, "_ctl_addr"}, 64'(ctl_wr_addr), 0);
    check({tag, "_ctl_wdata"}, 64'(ctl_wr_data), 0);
  endtask

  initial begin
    int r0;
    int n;
    logic [AW-1:0] base;
    int exp_retry;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 0;
    repeat (2) @(posedge clk);

    // single write
    pulse_q.delete();
    push(1'b1, 25'h0123456, 8'hA5);
    drain();
    check("wr_pulses", 64'(pulse_q.size()), 1);
    check("wr_hold_addr", 64'(ctl_wr_addr), 64'h0123456);
    check("wr_hold_data", 64'(ctl_wr_data), 64'hA5);
    check("wr_retry", 64'(retry_count), 0);

    // write then read back
    r0 = rsp_seen;
    push(1'b1, 25'h0123456, 8'hA5);
    push(1'b0, 25'h0123456, 8'h00);
    drain();
    check("wr_rd_rsp_count", 64'(rsp_seen - r0), 1);
    check("wr_rd_rsp_data", 64'(rsp_rdata), 64'hA5);

    // lost pulse is reissued
    pulse_q.delete();
    r0 = rsp_seen;
    drop_next = 1;
    push(1'b0, 25'h0000777, 8'h00);
    drain();
    check("retry_pulses", 64'(pulse_q.size()), 2);
    if (pulse_q.size() >= 2)
      check("retry_spacing", 64'(pulse_q[1] - pulse_q[0]), TMO + 2);
    check("retry_count_1", 64'(retry_count), 1);
    check("retry_rsp_count", 64'(rsp_seen - r0), 1);

    // fill with a stalled controller
    @(negedge clk) stall = 1;
    push(1'b1, 25'h10, 8'h11);
    push(1'b0, 25'h10, 8'h00);
    push(1'b1, 25'h20, 8'h22);
    push(1'b0, 25'h21, 8'h00);
    @(negedge clk);
    check("full_ready", 64'(req_ready), 0);
    check("full_count", 64'(fifo_count), DEPTH);
    stall = 0;
    push(1'b0, 25'h20, 8'h00);
    drain();

    // reset during read WAIT_DONE
    force_lat = 8;
    push(1'b0, 25'h0000333, 8'h00);
    n = 0;
    while (!ctl_busy && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("busy_seen", 64'(ctl_busy), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    exp_cmd.delete();
    exp_rsp.delete();
    have_last = 0;
    drops = 0;
    r0 = rsp_seen;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst = 0;
    force_lat = 0;
    repeat (20) @(posedge clk);
    check("midreset_no_rsp", 64'(rsp_seen - r0), 0);
    check("midreset_empty", 64'(fifo_count), 0);

    // random traffic
    base = 25'h0ABC00;
    rand_drop = 1;
    for (int i = 0; i < 200; i++) begin
      push(1'($urandom_range(0, 1)), base + AW'($urandom_range(0, 15)),
           8'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();
    rand_drop = 0;
    exp_retry = (drops > 255) ? 255 : drops;
    check("rand_retry_count", 64'(retry_count), 64'(exp_retry));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
